// File: rtl/chunk_vector_buffer_pkg.sv
// Shared types and helpers for the ping-pong chunk vector buffer.
//   byte_t        : one signed data byte, passed through bit-exact
//   bank_state_t  : life cycle of one bank (EMPTY/FILLING/FULL/DRAINING)
//   chunk_len_ok  : elaboration-time check that a chunk width tiles a vector
package chunk_vector_buffer_pkg;

  typedef logic signed [7:0] byte_t;

  // A bank goes EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  // FILLING is skipped when one write covers the whole vector, and
  // DRAINING is skipped when one pop covers the whole vector.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // True when a chunk of chunk_len bytes divides a vector of vec_len bytes.
  function automatic bit chunk_len_ok(input int vec_len, input int chunk_len);
    return (chunk_len > 0) && (chunk_len <= vec_len) && ((vec_len % chunk_len) == 0);
  endfunction

endpackage

// File: rtl/chunk_vector_buffer_vec_bank.sv
// One vector bank: InVecLength bytes of storage, written one WrRegs-byte
// slice per enabled edge and read combinationally one RdRegs-byte slice
// at a time. Storage is deliberately not reset; validity is tracked by
// the owner through its bank_full flags.
//   clk     : clock
//   wr_en   : write the slice at wr_idx this edge
//   wr_idx  : byte offset of the written slice (multiple of WrRegs)
//   wr_data : slice to write, byte 0 in the low bits
//   rd_idx  : byte offset of the read slice (multiple of RdRegs)
//   rd_data : slice at rd_idx
module vec_bank
  import chunk_vector_buffer_pkg::*;
#(
  parameter int InVecLength = 16,
  parameter int WrRegs      = 4,
  parameter int RdRegs      = 4,
  parameter int AddrW       = $clog2(InVecLength)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AddrW-1:0]         wr_idx,
  input  logic signed [WrRegs-1:0][7:0] wr_data,
  input  logic [AddrW-1:0]         rd_idx,
  output logic signed [RdRegs-1:0][7:0] rd_data
);

  byte_t [InVecLength-1:0] mem;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx +: WrRegs] <= wr_data;
  end

  assign rd_data = mem[rd_idx +: RdRegs];

endmodule

// File: rtl/chunk_vector_buffer.sv
// Ping-pong vector buffer between two streaming layers. The upstream
// layer writes WrRegs-byte chunks into one bank while the downstream
// layer pops RdRegs-byte chunks out of the other, so vector k+1 can be
// assembled while vector k is still being consumed.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   wr_chunk_valid : upstream chunk strobe
//   wr_data        : upstream chunk, byte 0 in the low bits
//   wr_vector_done : upstream end-of-vector marker (checked, not used for control)
//   rd_req_chunk   : downstream pop request
//   rd_data        : current read chunk (0 when nothing readable)
//   rd_data_ready  : a complete vector is readable
//   wr_full        : both banks hold unread vectors; upstream must stall
//   overflow_err   : sticky, a write arrived while its bank was full
//   underflow_err  : sticky, a pop arrived with nothing readable
//   framing_err    : sticky, wr_vector_done disagreed with vector completion
module chunk_vector_buffer
  import chunk_vector_buffer_pkg::*;
#(
  parameter int InVecLength = 16,
  parameter int WrRegs      = 4,
  parameter int RdRegs      = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          wr_chunk_valid,
  input  logic signed [WrRegs-1:0][7:0] wr_data,
  input  logic                          wr_vector_done,
  input  logic                          rd_req_chunk,
  output logic signed [RdRegs-1:0][7:0] rd_data,
  output logic                          rd_data_ready,
  output logic                          wr_full,
  output logic                          overflow_err,
  output logic                          underflow_err,
  output logic                          framing_err
);

  localparam int AddrW = $clog2(InVecLength);
  localparam int IdxW  = AddrW + 1;

  localparam logic [IdxW-1:0] WrStep = IdxW'(WrRegs);
  localparam logic [IdxW-1:0] RdStep = IdxW'(RdRegs);
  // Offset of the slice that completes / drains a vector.
  localparam logic [IdxW-1:0] WrLast = IdxW'(InVecLength - WrRegs);
  localparam logic [IdxW-1:0] RdLast = IdxW'(InVecLength - RdRegs);

  if (!chunk_len_ok(InVecLength, WrRegs)) begin : g_bad_wr_regs
    $error("WrRegs must divide InVecLength");
  end
  if (!chunk_len_ok(InVecLength, RdRegs)) begin : g_bad_rd_regs
    $error("RdRegs must divide InVecLength");
  end

  logic [1:0]      bank_full, bank_full_nxt;
  logic            wr_bank, rd_bank;
  logic [IdxW-1:0] wr_idx, rd_idx;

  logic wr_accept, wr_last, rd_pop, rd_last;

  logic signed [RdRegs-1:0][7:0] bank_rd [2];

  // Writes are gated purely on the registered full flag of the target
  // bank, so a release on the same edge never lets a write through.
  assign wr_accept = wr_chunk_valid & ~bank_full[wr_bank];
  assign wr_last   = (wr_idx == WrLast);
  assign rd_pop    = rd_req_chunk & rd_data_ready;
  assign rd_last   = (rd_idx == RdLast);

  assign rd_data_ready = bank_full[rd_bank];
  assign wr_full       = bank_full[0] & bank_full[1];
  assign rd_data       = rd_data_ready ? bank_rd[rd_bank] : '0;

  // A write can only target a non-full bank and a pop only a full one, so
  // set and clear never hit the same bank on one edge.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_accept && wr_last) bank_full_nxt[wr_bank] = 1'b1;
    if (rd_pop && rd_last)    bank_full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bank_full     <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      framing_err   <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;

      if (wr_accept) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx  <= wr_idx + WrStep;
        end
        // The upstream marker is only advisory; the write proceeds anyway.
        if (wr_vector_done != wr_last) framing_err <= 1'b1;
      end
      if (wr_chunk_valid && bank_full[wr_bank]) overflow_err <= 1'b1;

      if (rd_pop) begin
        if (rd_last) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_idx  <= rd_idx + RdStep;
        end
      end
      if (rd_req_chunk && !rd_data_ready) underflow_err <= 1'b1;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    vec_bank #(
      .InVecLength(InVecLength),
      .WrRegs     (WrRegs),
      .RdRegs     (RdRegs),
      .AddrW      (AddrW)
    ) u_bank (
      .clk    (clk_in),
      .wr_en  (wr_accept && (wr_bank == 1'(b))),
      .wr_idx (wr_idx[AddrW-1:0]),
      .wr_data(wr_data),
      .rd_idx (rd_idx[AddrW-1:0]),
      .rd_data(bank_rd[b])
    );
  end

endmodule
